// File: rtl/uart_tx_fifo_if.sv
// Host-side bundle for the FIFO-fed UART transmitter: byte push, baud tick, serial line and status.
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] din;
  logic                 wr_en;
  logic                 clken;
  logic                 tx;
  logic                 tx_busy;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 overflow;

  modport master (
    output din, wr_en, clken,
    input  tx, tx_busy, fifo_full, fifo_empty, overflow
  );

  modport slave (
    input  din, wr_en, clken,
    output tx, tx_busy, fifo_full, fifo_empty, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; frames go out back-to-back on the external baud tick.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic           clk_5m,
  input logic           rst_n,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               state, state_next;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wptr, rptr;
  logic [CNT_W-1:0]     count, count_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic [BIT_W-1:0]     bitcnt, bitcnt_next;
  logic                 stop_cnt, stop_cnt_next;
  logic                 par_bit, par_bit_next;
  logic                 tx_q, tx_next;
  logic                 full_q, empty_q, busy_q, ovf_q;
  logic                 push, pop;

  // Writes are gated by the registered full flag, so a same-cycle pop never rescues a full write.
  assign push = bus.wr_en & ~full_q;

  always_comb begin
    state_next    = state;
    shreg_next    = shreg;
    bitcnt_next   = bitcnt;
    stop_cnt_next = stop_cnt;
    par_bit_next  = par_bit;
    tx_next       = tx_q;
    pop           = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty_q) begin
          pop           = 1'b1;
          shreg_next    = mem[rptr];
          par_bit_next  = (PARITY == 1) ? ~^mem[rptr] : ^mem[rptr];
          bitcnt_next   = '0;
          stop_cnt_next = 1'b0;
          state_next    = S_START;
        end
      end
      S_START: begin
        if (bus.clken) begin
          tx_next    = 1'b0;
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.clken) begin
          tx_next     = shreg[0];
          shreg_next  = shreg >> 1;
          bitcnt_next = bitcnt + BIT_W'(1);
          if (bitcnt == BIT_W'(DATA_BITS - 1)) begin
            state_next = (PARITY != 0) ? S_PAR : S_STOP;
          end
        end
      end
      S_PAR: begin
        if (bus.clken) begin
          tx_next    = par_bit;
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (bus.clken) begin
          tx_next = 1'b1;
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            state_next = S_IDLE;
          end else begin
            stop_cnt_next = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
    count_next = count + CNT_W'(push) - CNT_W'(pop);
  end

  // Flags and busy are registered from next-state values so they match the post-edge contents.
  always_ff @(posedge clk_5m or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      shreg    <= '0;
      bitcnt   <= '0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
      tx_q     <= 1'b1;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_next;
      shreg    <= shreg_next;
      bitcnt   <= bitcnt_next;
      stop_cnt <= stop_cnt_next;
      par_bit  <= par_bit_next;
      tx_q     <= tx_next;
      count    <= count_next;
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      full_q   <= (count_next == CNT_W'(FIFO_DEPTH));
      empty_q  <= (count_next == '0);
      busy_q   <= (state_next != S_IDLE) | (count_next != '0);
      ovf_q    <= bus.wr_en & full_q;
    end
  end

  always_ff @(posedge clk_5m) begin
    if (push) mem[wptr] <= bus.din;
  end

  assign bus.tx         = tx_q;
  assign bus.tx_busy    = busy_q;
  assign bus.fifo_full  = full_q;
  assign bus.fifo_empty = empty_q;
  assign bus.overflow   = ovf_q;

endmodule
